// File: rtl/icache_direct_if.sv
// Fetch-side bus (core <-> cache) and line-refill bus (cache <-> memory bridge)
// used by icache_direct.
interface icache_ibus_if;
  logic        ibus_read;
  logic [31:0] ibus_vaddr;
  logic [31:0] ibus_paddr;
  logic        ibus_inv;
  logic [31:0] ibus_inv_addr;
  logic        ibus_ready;
  logic        ibus_valid;
  logic [31:0] ibus_rddata;

  modport master (
    output ibus_read, ibus_vaddr, ibus_paddr, ibus_inv, ibus_inv_addr,
    input  ibus_ready, ibus_valid, ibus_rddata
  );
  modport slave (
    input  ibus_read, ibus_vaddr, ibus_paddr, ibus_inv, ibus_inv_addr,
    output ibus_ready, ibus_valid, ibus_rddata
  );
endinterface

interface icache_mem_if;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        mem_rlast;

  modport master (
    output mem_req, mem_addr,
    input  mem_gnt, mem_rvalid, mem_rdata, mem_rlast
  );
  modport slave (
    input  mem_req, mem_addr,
    output mem_gnt, mem_rvalid, mem_rdata, mem_rlast
  );
endinterface

// File: rtl/icache_direct.sv
// Direct-mapped read-only instruction cache: stage 1 indexes with the next-PC,
// stage 2 compares tags against the translated PC; misses refill a whole line.
module icache_direct #(
  parameter int LINE_WIDTH = 256,
  parameter int CACHE_SIZE = 8192
) (
  input logic          clk,
  input logic          rst,
  icache_ibus_if.slave ibus,
  icache_mem_if.master mem
);
  localparam int WPL    = LINE_WIDTH / 32;
  localparam int N_SETS = CACHE_SIZE * 8 / LINE_WIDTH;
  localparam int OFF_W  = $clog2(LINE_WIDTH / 8);
  localparam int IDX_W  = $clog2(N_SETS);
  localparam int TAG_W  = 32 - OFF_W - IDX_W;
  localparam int WOFF_W = OFF_W - 2;

  typedef enum logic [1:0] {RUN, MISS_REQ, REFILL, FILL_DONE} state_e;

  state_e                  r_state, w_next_state;
  logic [N_SETS-1:0]       r_valid;
  logic [TAG_W-1:0]        r_tag_ram  [N_SETS];
  logic [LINE_WIDTH-1:0]   r_data_ram [N_SETS];
  logic [TAG_W-1:0]        r_rd_tag;
  logic [LINE_WIDTH-1:0]   r_rd_line;
  logic                    r_s2_valid;
  logic [IDX_W-1:0]        r_s2_idx;
  logic [WOFF_W-1:0]       r_s2_woff;
  logic [31:0]             r_miss_addr;
  logic [IDX_W-1:0]        r_miss_idx;
  logic [WOFF_W-1:0]       r_miss_woff;
  logic [LINE_WIDTH-1:0]   r_fill_line;
  logic [WOFF_W-1:0]       r_beat_cnt;

  logic [IDX_W-1:0]        w_rd_idx, w_inv_idx;
  logic [WOFF_W-1:0]       w_rd_woff;
  logic                    w_tag_match, w_hit, w_miss, w_inv_take;
  logic                    w_accept, w_beat, w_last;
  logic                    w_ready, w_valid, w_mem_req;
  logic [31:0]             w_rddata;
  logic [LINE_WIDTH-1:0]   w_fill_line;
  logic                    w_unused;

  assign w_rd_idx    = ibus.ibus_vaddr[OFF_W+IDX_W-1:OFF_W];
  assign w_rd_woff   = ibus.ibus_vaddr[OFF_W-1:2];
  assign w_inv_idx   = ibus.ibus_inv_addr[OFF_W+IDX_W-1:OFF_W];
  assign w_tag_match = (r_rd_tag == ibus.ibus_paddr[31:32-TAG_W]);
  // valid[] is read before this edge's invalidate lands, so an in-flight
  // lookup to the set being invalidated still sees the old bit.
  assign w_hit       = (r_state == RUN) && r_s2_valid && r_valid[r_s2_idx] && w_tag_match;
  assign w_miss      = (r_state == RUN) && r_s2_valid && !(r_valid[r_s2_idx] && w_tag_match);
  assign w_inv_take  = (r_state == RUN) && ibus.ibus_inv;
  assign w_accept    = ibus.ibus_read && w_ready;
  assign w_beat      = (r_state == REFILL) && mem.mem_rvalid;
  assign w_last      = w_beat && mem.mem_rlast;

  assign w_unused = ^{ibus.ibus_vaddr[1:0], ibus.ibus_vaddr[31:OFF_W+IDX_W],
                      ibus.ibus_paddr[OFF_W-1:0], ibus.ibus_inv_addr[31:OFF_W+IDX_W],
                      ibus.ibus_inv_addr[OFF_W-1:0]};

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) r_state <= RUN;
    else     r_state <= w_next_state;
  end

  // NOTE: every signal gets a default first so no path through the block infers a latch.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      RUN:       if (w_miss) w_next_state = MISS_REQ;
      MISS_REQ:  if (mem.mem_gnt) w_next_state = REFILL;
      REFILL:    if (w_last) w_next_state = FILL_DONE;
      FILL_DONE: w_next_state = RUN;
      default:   w_next_state = RUN;
    endcase
  end

  always_comb begin
    w_ready   = 1'b0;
    w_valid   = 1'b0;
    w_rddata  = '0;
    w_mem_req = 1'b0;
    case (r_state)
      RUN: begin
        w_ready = !w_miss && !ibus.ibus_inv;
        w_valid = w_hit;
        if (w_hit) w_rddata = r_rd_line[{r_s2_woff, 5'b0} +: 32];
      end
      MISS_REQ:  w_mem_req = 1'b1;
      FILL_DONE: begin
        w_ready  = 1'b1;
        w_valid  = 1'b1;
        w_rddata = r_fill_line[{r_miss_woff, 5'b0} +: 32];
      end
      default: ;
    endcase
  end

  assign ibus.ibus_ready  = w_ready;
  assign ibus.ibus_valid  = w_valid;
  assign ibus.ibus_rddata = w_rddata;
  assign mem.mem_req      = w_mem_req;
  assign mem.mem_addr     = r_miss_addr;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid     <= '0;
      r_s2_valid  <= 1'b0;
      r_s2_idx    <= '0;
      r_s2_woff   <= '0;
      r_miss_addr <= '0;
      r_miss_idx  <= '0;
      r_miss_woff <= '0;
      r_beat_cnt  <= '0;
    end else begin
      r_s2_valid <= w_accept;
      if (w_accept) begin
        r_s2_idx  <= w_rd_idx;
        r_s2_woff <= w_rd_woff;
      end
      if (w_miss) begin
        r_miss_addr <= {ibus.ibus_paddr[31:OFF_W], {OFF_W{1'b0}}};
        r_miss_idx  <= r_s2_idx;
        r_miss_woff <= r_s2_woff;
      end
      if ((r_state == MISS_REQ) && mem.mem_gnt) r_beat_cnt <= '0;
      else if (w_beat)                          r_beat_cnt <= r_beat_cnt + WOFF_W'(1);
      if (w_inv_take) r_valid[w_inv_idx]  <= 1'b0;
      if (w_last)     r_valid[r_miss_idx] <= 1'b1;
    end
  end

  // The final beat bypasses the fill buffer so the RAM write happens on rlast.
  always_comb begin
    w_fill_line = r_fill_line;
    w_fill_line[{r_beat_cnt, 5'b0} +: 32] = mem.mem_rdata;
  end

  // NOTE: the RAMs and fill buffer are not reset; r_valid alone qualifies their contents.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_rd_tag  <= r_tag_ram[w_rd_idx];
      r_rd_line <= r_data_ram[w_rd_idx];
    end
    if (w_beat) r_fill_line[{r_beat_cnt, 5'b0} +: 32] <= mem.mem_rdata;
    if (w_last) begin
      r_tag_ram[r_miss_idx]  <= r_miss_addr[31:32-TAG_W];
      r_data_ram[r_miss_idx] <= w_fill_line;
    end
  end

  a_rlast_on_final_beat: assert property (@(posedge clk) disable iff (rst)
    (r_state == REFILL && mem.mem_rvalid && mem.mem_rlast) |-> (r_beat_cnt == WOFF_W'(WPL - 1)));

endmodule
